// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the data-memory access unit (mem_access_unit).
package mau_pkg;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    DONE = ST_DONE
  } mau_state_t;

  function automatic logic [3:0] mau_byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_B:   return 4'b0001 << off;
      MEM_H:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] mau_replicate(input logic [1:0] size, input logic [31:0] data);
    case (size)
      MEM_B:   return {4{data[7:0]}};
      MEM_H:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  // Reserved size 2'b11 is folded into the misalignment condition.
  function automatic logic mau_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == MEM_H) && off[0]) ||
           ((size == MEM_W) && (off != 2'b00)) ||
           (size == 2'b11);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Handshaked data-memory bus between mem_access_unit (master) and the memory (slave).
interface mau_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Load formatting: picks the addressed lane of a read word and sign/zero extends it.
module mau_load_align
  import mau_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        u_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      MEM_B:   data_o = {{24{byte_sel[7] & ~u_i}}, byte_sel};
      MEM_H:   data_o = {{16{half_sel[15] & ~u_i}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: stalls the pipeline until the data memory acks.
// Optional bus watchdog enabled by defining MAU_TIMEOUT_EN.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  type_i,
  input  logic        u,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall_mem,
  output logic [31:0] rdata_o,
  output logic        rdata_valid,
  output logic        misalign_o,
  output logic        bus_err_o,
  mau_mem_if.master   mem
);

  mau_state_t  state_q, state_d;
  logic        we_q, we_d;
  logic [29:0] maddr_q, maddr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        u_q, u_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;

  logic        is_mem;
  logic        mis_cond;
  logic        accept;
  logic        expire;
  logic [31:0] load_data;

  assign is_mem   = req_valid & (MemRead | MemWrite);
  assign mis_cond = is_mem & mau_misaligned(type_i, addr[1:0]);
  assign accept   = (state_q == IDLE) & is_mem & ~mis_cond;

  // Gated by rst so every output reads 0 while reset is held.
  assign stall_mem  = ~rst & (accept | (state_q == BUSY));
  assign misalign_o = ~rst & (state_q == IDLE) & mis_cond;

  assign mem.mem_req   = (state_q == BUSY);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = {maddr_q, 2'b00};
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

  assign rdata_o     = rdata_q;
  assign rdata_valid = rvalid_q;
  assign bus_err_o   = err_q;

  mau_load_align u_load_align (
    .word_i (mem.mem_rdata),
    .off_i  (off_q),
    .size_i (size_q),
    .u_i    (u_q),
    .data_o (load_data)
  );

`ifdef MAU_TIMEOUT_EN
  localparam int unsigned CNT_LOG = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W   = (CNT_LOG > 8) ? CNT_LOG : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts BUSY cycles already spent; expiry lands on the TIMEOUT_CYCLES-th one.
  assign expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign cnt_d  = (state_q == BUSY) ? cnt_q + CNT_W'(1) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    maddr_d  = maddr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    off_d    = off_q;
    size_d   = size_q;
    u_d      = u_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          we_d    = MemWrite;
          maddr_d = addr[31:2];
          be_d    = MemWrite ? mau_byte_en(type_i, addr[1:0]) : '0;
          wdata_d = mau_replicate(type_i, wdata);
          off_d   = addr[1:0];
          size_d  = type_i;
          u_d     = u;
        end
      end
      BUSY: begin
        if (mem.mem_ack) begin
          state_d = DONE;
          if (!we_q) begin
            rdata_d  = load_data;
            rvalid_d = 1'b1;
          end
        end else if (expire) begin
          state_d = DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      off_q    <= '0;
      size_q   <= '0;
      u_q      <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      maddr_q  <= maddr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      off_q    <= off_d;
      size_q   <= size_d;
      u_q      <= u_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-level reference memory, random + directed traffic.
module tb_mem_access_unit;

`ifdef MAU_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, MemRead, MemWrite, u;
  logic [1:0]  type_i;
  logic [31:0] addr, wdata;
  logic        stall_mem, rdata_valid, misalign_o, bus_err_o;
  logic [31:0] rdata_o;

  mau_mem_if mif ();

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .type_i      (type_i),
    .u           (u),
    .addr        (addr),
    .wdata       (wdata),
    .stall_mem   (stall_mem),
    .rdata_o     (rdata_o),
    .rdata_valid (rdata_valid),
    .misalign_o  (misalign_o),
    .bus_err_o   (bus_err_o),
    .mem         (mif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] load_q[$];
  int          stall_q[$];
  int          mis_q[$];
  int          err_q[$];
  int          delay_q[$];

  logic [7:0]  ref_bytes [0:1023];
  logic [31:0] phys_mem  [0:255];

  int n_checks = 0;
  int n_err    = 0;
  bit tb_done  = 1'b0;
  int stray_req  = 0;
  int stray_done = 0;

  function automatic logic [31:0] init_word(input int i);
    return i * 32'h9E3779B9 ^ 32'h5A5A1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory slave ----------------
  initial begin : slave
    bit pend;
    int wait_left;
    logic [31:0] w;
    pend = 1'b0;
    wait_left = 0;
    mif.mem_ack = 1'b0;
    mif.mem_rdata = '0;
    for (int i = 0; i < 256; i++) phys_mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      #1;
      mif.mem_ack = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else if (stray_req != stray_done) begin
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 32'hFFFF_FFFF;
        stray_done++;
      end else if (mif.mem_req) begin
        if (!pend) begin
          pend = 1'b1;
          wait_left = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
        end
        if (wait_left == 0) begin
          w = phys_mem[mif.mem_addr[9:2]];
          mif.mem_ack   = 1'b1;
          mif.mem_rdata = w;
          if (mif.mem_we)
            for (int k = 0; k < 4; k++)
              if (mif.mem_be[k]) w[8*k +: 8] = mif.mem_wdata[8*k +: 8];
          phys_mem[mif.mem_addr[9:2]] = w;
          pend = 1'b0;
        end else begin
          wait_left--;
        end
      end else begin
        pend = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic prev_req = 1'b0;
  int   run = 0;
  int   cyc = 0;

  always @(negedge clk) begin
    bus_t        e;
    logic [31:0] ld;
    int          st;
    cyc++;
    if (cyc > 20000) begin
      chk("cycle_budget", 32'(cyc), 32'(20000));
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
    end
    if (rst) begin
      chk("rst_ctrl", 32'({stall_mem, mif.mem_req, rdata_valid, misalign_o,
                           bus_err_o, mif.mem_we, mif.mem_be}), 32'h0);
      chk("rst_rdata", rdata_o, 32'h0);
      chk("rst_mem_addr", mif.mem_addr, 32'h0);
      chk("rst_mem_wdata", mif.mem_wdata, 32'h0);
      run = 0;
      prev_req = 1'b0;
    end else begin
      if (mif.mem_req && !prev_req) begin
        if (bus_q.size() == 0) chk("mem_req_unexpected", 32'(mif.mem_req), 32'h0);
        else begin
          e = bus_q.pop_front();
          chk("mem_addr", mif.mem_addr, e.addr);
          chk("mem_we", 32'(mif.mem_we), 32'(e.we));
          chk("mem_be", 32'(mif.mem_be), 32'(e.be));
          if (e.we) chk("mem_wdata", mif.mem_wdata, e.wdata);
        end
      end
      if (rdata_valid) begin
        if (load_q.size() == 0) chk("rdata_valid_unexpected", 32'(rdata_valid), 32'h0);
        else begin
          ld = load_q.pop_front();
          chk("load_data", rdata_o, ld);
        end
      end
      if (misalign_o) begin
        if (mis_q.size() == 0) chk("misalign_unexpected", 32'(misalign_o), 32'h0);
        else begin
          void'(mis_q.pop_front());
          chk("misalign_no_stall_no_req", 32'({stall_mem, mif.mem_req}), 32'h0);
        end
      end
      if (bus_err_o) begin
        if (err_q.size() == 0) chk("bus_err_unexpected", 32'(bus_err_o), 32'h0);
        else begin
          void'(err_q.pop_front());
          chk("timeout_rdata", rdata_o, 32'h0);
          chk("timeout_no_valid", 32'(rdata_valid), 32'h0);
        end
      end
      if (stall_mem) run++;
      else if (run > 0) begin
        if (stall_q.size() == 0) chk("stall_unexpected", 32'(run), 32'h0);
        else begin
          st = stall_q.pop_front();
          chk("stall_cycles", 32'(run), 32'(st));
        end
        run = 0;
      end
      prev_req = mif.mem_req;
    end
    if (tb_done) begin
      chk("queues_drained", 32'(bus_q.size() + load_q.size() + stall_q.size() +
                                mis_q.size() + err_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
    end
  end

  // ---------------- driver + reference model ----------------
  task automatic drive_idle();
    req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    type_i = 2'b00; u = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input bit uu);
    req_valid = 1'b1; MemRead = rd; MemWrite = wr;
    type_i = sz; u = uu; addr = a; wdata = wd;
  endtask

  task automatic wait_retire();
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!stall_mem) break;
    end
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  function automatic bus_t exp_bus(input bit wr, input logic [1:0] sz,
                                   input logic [31:0] a, input logic [31:0] wd);
    bus_t e;
    e.we   = wr;
    e.addr = a & 32'hFFFF_FFFC;
    if (!wr)           e.be = 4'h0;
    else if (sz == 0)  e.be = 4'(1 << a[1:0]);
    else if (sz == 1)  e.be = 4'(3 << a[1:0]);
    else               e.be = 4'hF;
    if (sz == 0)       e.wdata = {24'b0, wd[7:0]} * 32'h0101_0101;
    else if (sz == 1)  e.wdata = {16'b0, wd[15:0]} * 32'h0001_0001;
    else               e.wdata = wd;
    return e;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic [31:0] a, input bit uu);
    logic [31:0] v;
    int nb;
    nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    v = '0;
    for (int i = 0; i < nb; i++) v = v | ({24'b0, ref_bytes[a + i]} << (8 * i));
    if (!uu && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!uu && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic issue(input bit rd, input bit wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input bit uu, input int d);
    bit aligned;
    int nb;
    aligned = (sz == 0) || (sz == 1 && !a[0]) || (sz == 2 && a[1:0] == 2'b00);
    if (!aligned) begin
      mis_q.push_back(1);
    end else begin
      bus_q.push_back(exp_bus(wr, sz, a, wd));
      delay_q.push_back(d);
      stall_q.push_back(d + 2);
      if (wr) begin
        nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        for (int i = 0; i < nb; i++) ref_bytes[a + i] = wd[8*i +: 8];
      end else begin
        load_q.push_back(ref_load(sz, a, uu));
      end
    end
    drive(rd, wr, sz, a, wd, uu);
    wait_retire();
  endtask

  initial begin : driver
    logic [31:0] w;
    logic [31:0] a;
    int op;
    for (int i = 0; i < 256; i++) begin
      w = init_word(i);
      for (int k = 0; k < 4; k++) ref_bytes[4*i + k] = w[8*k +: 8];
    end
    rst = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // directed
    issue(0, 1, 2'b10, 32'h100, 32'h80FF_0000, 0, 0);
    issue(0, 1, 2'b10, 32'h000, 32'hDEAD_BEEF, 0, 1);
    issue(1, 0, 2'b00, 32'h103, 32'h0, 0, 0);
    issue(0, 1, 2'b01, 32'h202, 32'h1234_ABCD, 0, 2);
    issue(1, 0, 2'b10, 32'h205, 32'h0, 0, 0);
    issue(1, 0, 2'b00, 32'h003, 32'h0, 1, 0);
    issue(1, 0, 2'b01, 32'h002, 32'h0, 1, 0);
    issue(1, 1, 2'b00, 32'h011, 32'h0000_00A5, 0, 3);
    issue(1, 0, 2'b11, 32'h040, 32'h0, 0, 0);

    // reset while BUSY with ack withheld, then a stray ack
    bus_q.push_back(exp_bus(0, 2'b10, 32'h010, 32'h0));
    delay_q.push_back(1000);
    drive(1, 0, 2'b10, 32'h010, 32'h0, 0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    drive_idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    stray_req++;
    repeat (3) begin
      @(posedge clk);
      #1;
    end

`ifdef MAU_TIMEOUT_EN
    bus_q.push_back(exp_bus(0, 2'b10, 32'h040, 32'h0));
    delay_q.push_back(1000);
    stall_q.push_back(TO + 1);
    err_q.push_back(1);
    drive(1, 0, 2'b10, 32'h040, 32'h0, 0);
    wait_retire();
`endif

    // random traffic
    for (int n = 0; n < 150; n++) begin
      a = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
      op = int'($urandom_range(0, 3));
      issue(op != 2, op >= 2, 2'($urandom_range(0, 3)), a, $urandom,
            $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (4) begin
      @(posedge clk);
      #1;
    end
    tb_done = 1'b1;
  end

endmodule
